morse_letter_decoder: RTL and testbench

MORSE_LETTER_DECODER -- requirements
Module: morse_letter_decoder

---
 rtl/morse_pkg.sv | 19 +
 rtl/morse_lut.sv | 19 +
 rtl/morse_letter_decoder.sv | 93 +++++++++
 tb/tb_morse_letter_decoder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: FSM states, letter codes and the (length, pattern) table shared by the decoder.
package morse_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_EMIT} state_e;
  typedef enum logic [4:0] {
    L_A, L_B, L_C, L_D, L_E, L_F, L_G, L_H, L_I, L_J, L_K, L_L, L_M,
    L_N, L_O, L_P, L_Q, L_R, L_S, L_T, L_U, L_V, L_W, L_X, L_Y, L_Z
  } letter_e;
  localparam int N_LETTERS = 26;
  // Dot=0, dash=1; first symbol sits in the MSB of the len-bit field.
  localparam logic [2:0] MORSE_LEN [N_LETTERS] = '{
    3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4, 3'd2, 3'd4, 3'd3, 3'd4, 3'd2,
    3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd1, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4
  };
  localparam logic [3:0] MORSE_PAT [N_LETTERS] = '{
    4'b0001, 4'b1000, 4'b1010, 4'b0100, 4'b0000, 4'b0010, 4'b0110, 4'b0000, 4'b0000,
    4'b0111, 4'b0101, 4'b0100, 4'b0011, 4'b0010, 4'b0111, 4'b0110, 4'b1101, 4'b0010,
    4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b1001, 4'b1011, 4'b1100
  };
endpackage

// File: rtl/morse_lut.sv
// morse_lut: combinational (length, pattern) to letter code lookup.
module morse_lut
  import morse_pkg::*;
(
  input  logic [3:0] sym,
  input  logic [2:0] sym_len,
  output logic [4:0] code,
  output logic       hit
);
  always_comb begin
    code = '0;
    hit  = 1'b0;
    for (int i = 0; i < N_LETTERS; i++)
      if (sym_len == MORSE_LEN[i] && sym == MORSE_PAT[i]) begin
        code = 5'(i);
        hit  = 1'b1;
      end
  end
endmodule

// File: rtl/morse_letter_decoder.sv
// morse_letter_decoder: times key presses into dots/dashes and emits one decoded letter per gap.
module morse_letter_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = 1000000,
  parameter int DOT_MAX   = 20,
  parameter int GAP_TICKS = 40
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Key,
  output logic [4:0] letter_code,
  output logic       letter_valid,
  output logic       letter_err,
  output logic [2:0] sym_len,
  output logic       busy
);
  localparam int PW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int DMAX = DOT_MAX > GAP_TICKS ? DOT_MAX : GAP_TICKS;
  localparam int DW   = $clog2(DMAX + 1);
  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [3:0]    sym_q, sym_d;
  logic [2:0]    len_q, len_d;
  logic [4:0]    code_q, code_d, lut_code;
  logic          valid_q, valid_d, err_q, err_d, key_q, tick, lut_hit;
  morse_lut u_lut (.sym(sym_q), .sym_len(len_q), .code(lut_code), .hit(lut_hit));
  assign tick  = pre_q == PW'(TICK_DIV - 1);
  assign pre_d = (Key != key_q || tick) ? '0 : pre_q + 1'b1;
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    sym_d   = sym_q;
    len_d   = len_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (Key) begin
        state_d = S_PRESS;
        dur_d   = '0;
      end
      S_PRESS: if (!Key) begin
        state_d = S_GAP;
        dur_d   = '0;
        sym_d   = len_q < 3'd4 ? {sym_q[2:0], dur_q >= DW'(DOT_MAX)} : sym_q;
        len_d   = len_q < 3'd4 ? len_q + 3'd1 : 3'd5;
      end else if (tick && dur_q < DW'(DOT_MAX)) dur_d = dur_q + 1'b1;
      S_GAP: if (Key) begin
        state_d = S_PRESS;
        dur_d   = '0;
      end else if (dur_q == DW'(GAP_TICKS)) state_d = S_EMIT;
      else if (tick) dur_d = dur_q + 1'b1;
      default: begin
        state_d = S_IDLE;
        sym_d   = '0;
        len_d   = '0;
        valid_d = lut_hit;
        err_d   = !lut_hit;
        code_d  = lut_hit ? lut_code : code_q;
      end
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      dur_q   <= '0;
      sym_q   <= '0;
      len_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dur_q   <= dur_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      key_q   <= Key;
    end
  end
  assign letter_code  = code_q;
  assign letter_valid = valid_q;
  assign letter_err   = err_q;
  assign sym_len      = len_q;
  assign busy         = state_q != S_IDLE;
endmodule

// File: tb/tb_morse_letter_decoder.sv
// tb_morse_letter_decoder: directed key sequences with a scoreboard of expected letter/error pulses.
module tb_morse_letter_decoder;
  localparam int TD = 4;
  logic       Clk = 1'b0, Reset = 1'b1, Key = 1'b0;
  logic [4:0] letter_code;
  logic       letter_valid, letter_err, busy;
  logic [2:0] sym_len;
  typedef struct {logic v; logic e; logic [4:0] c; string name;} exp_t;
  exp_t exp_q[$];
  int passed = 0, total = 0;

  morse_letter_decoder #(.TICK_DIV(TD), .DOT_MAX(3), .GAP_TICKS(5)) dut (
    .Clk(Clk), .Reset(Reset), .Key(Key), .letter_code(letter_code),
    .letter_valid(letter_valid), .letter_err(letter_err), .sym_len(sym_len), .busy(busy)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (letter_valid || letter_err) begin
      total++;
      if (exp_q.size() == 0)
        $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%0d, required none", letter_valid, letter_err, letter_code);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        if (letter_valid === e.v && letter_err === e.e && letter_code === e.c) passed++;
        else $display("FAIL %s: valid=%0b err=%0b code=%0d, required valid=%0b err=%0b code=%0d",
                      e.name, letter_valid, letter_err, letter_code, e.v, e.e, e.c);
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [4:0] c);
    exp_t e;
    e.v = v; e.e = !v; e.c = c; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic press(input int n);
    Key = 1'b1;
    repeat (n * TD + 1) @(negedge Clk);
    Key = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n * TD + 1) @(negedge Clk);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      press(s[i] == "-" ? 5 : 1);
      if (i < s.len() - 1) gap(1);
    end
  endtask

  task automatic settle();
    repeat (35) @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_code", letter_code, 0);
    chk("rst_valid", letter_valid, 0);
    chk("rst_err", letter_err, 0);
    chk("rst_len", sym_len, 0);
    chk("rst_busy", busy, 0);
    Reset = 1'b0;
    @(negedge Clk);
    expect_out("letter_A", 1'b1, 5'd0);
    press(2); gap(1); press(5);
    settle();
    expect_out("letter_H", 1'b1, 5'd7);
    send("....");
    @(negedge Clk);
    chk("H_len4", sym_len, 4);
    chk("H_busy", busy, 1);
    settle();
    expect_out("err_..--", 1'b0, 5'd7);
    send("..--");
    settle();
    chk("err_code_kept", letter_code, 7);
    expect_out("err_five_dots", 1'b0, 5'd7);
    send(".....");
    @(negedge Clk);
    chk("five_len5", sym_len, 5);
    settle();
    press(1); gap(1); press(5); gap(1);
    Key = 1'b1;
    repeat (3) @(negedge Clk);
    chk("mid_len2", sym_len, 2);
    Reset = 1'b1; Key = 1'b0;
    repeat (2) @(negedge Clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_len", sym_len, 0);
    chk("mid_rst_code", letter_code, 0);
    Reset = 1'b0;
    settle();
    expect_out("letter_C", 1'b1, 5'd2);
    send("-.-.");
    settle();
    expect_out("dash_at_dotmax_T", 1'b1, 5'd19);
    press(3);
    settle();
    expect_out("dot_below_dotmax_E", 1'b1, 5'd4);
    press(2);
    settle();
    expect_out("gap4_keeps_letter_A", 1'b1, 5'd0);
    press(1); gap(4); press(4);
    settle();
    expect_out("letter_Z", 1'b1, 5'd25);
    send("--..");
    settle();
    expect_out("letter_Y", 1'b1, 5'd24);
    send("-.--");
    settle();
    Key = 1'b1;
    repeat (200) @(negedge Clk);
    chk("held_busy", busy, 1);
    chk("held_len", sym_len, 0);
    expect_out("held_then_T", 1'b1, 5'd19);
    Key = 1'b0;
    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
